countdown_sequencer: RTL and testbench

//  Control stage wrapped around the 4-bit down counter (counter: load=1 captures load_signal,

---
 rtl/countdown_sequencer.sv | 117 +++++++++++
 tb/tb_countdown_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_sequencer.sv
// Job sequencer driving an external down counter: reloads it once per period and
// pulses tick/done. Optional shadow check of the counter via CNTSEQ_SHADOW_CHECK_EN.
module countdown_sequencer #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned REPEAT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [WIDTH-1:0]    start_period,
    input  logic [REPEAT_W-1:0] start_repeat,
    input  logic                abort,
    input  logic [WIDTH-1:0]    q,
    output logic                load,
    output logic [WIDTH-1:0]    load_signal,
    output logic                tick,
    output logic                done,
    output logic                busy,
    output logic                err
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    period_q, period_d;
    logic [REPEAT_W-1:0] rem_q, rem_d;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        rem_d       = rem_q;
        start_ready = 1'b0;
        load        = 1'b0;
        load_signal = '0;
        tick        = 1'b0;
        done        = 1'b0;
        busy        = (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                start_ready = !abort;
                if (start_valid && !abort) begin
                    period_d = start_period;
                    rem_d    = start_repeat;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                load_signal = period_q;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                load_signal = period_q;
                if (abort) begin
                    state_d = StIdle;
                end else if (q == '0) begin
                    tick = 1'b1;
                    // Reload while periods remain; the last expiry just finishes the job.
                    if (rem_q != '0) begin
                        load  = 1'b1;
                        rem_d = rem_q - REPEAT_W'(1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            period_q <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            rem_q    <= rem_d;
        end
    end

`ifdef CNTSEQ_SHADOW_CHECK_EN
    // exp mirrors what the counter should hold given what we told it to do.
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;

    always_comb begin
        exp_d = load ? load_signal : exp_q - WIDTH'(1);
        err_d = err_q | ((state_q == StRun) && (q != exp_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with a behavioural down counter on q/load.
module tb_countdown_sequencer;

    localparam int unsigned WIDTH    = 4;
    localparam int unsigned REPEAT_W = 4;
`ifdef CNTSEQ_SHADOW_CHECK_EN
    localparam bit ShadowEn = 1'b1;
`else
    localparam bit ShadowEn = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                start_valid;
    logic                start_ready;
    logic [WIDTH-1:0]    start_period;
    logic [REPEAT_W-1:0] start_repeat;
    logic                abort;
    logic [WIDTH-1:0]    q;
    logic                load;
    logic [WIDTH-1:0]    load_signal;
    logic                tick;
    logic                done;
    logic                busy;
    logic                err;

    logic [WIDTH-1:0] cnt = '0;
    logic             force_en = 1'b0;
    logic [WIDTH-1:0] force_val = '0;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (load) cnt <= load_signal;
        else      cnt <= cnt - 4'd1;
    end

    assign q = force_en ? force_val : cnt;

    countdown_sequencer #(.WIDTH(WIDTH), .REPEAT_W(REPEAT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_period(start_period),
        .start_repeat(start_repeat),
        .abort       (abort),
        .q           (q),
        .load        (load),
        .load_signal (load_signal),
        .tick        (tick),
        .done        (done),
        .busy        (busy),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_cycle(input string t, input int c, input bit e_rdy, input bit e_load,
                             input bit e_tick, input bit e_done, input bit e_busy);
        check($sformatf("%s c%0d ready", t, c), 32'(start_ready), 32'(e_rdy));
        check($sformatf("%s c%0d load", t, c), 32'(load), 32'(e_load));
        check($sformatf("%s c%0d tick", t, c), 32'(tick), 32'(e_tick));
        check($sformatf("%s c%0d done", t, c), 32'(done), 32'(e_done));
        check($sformatf("%s c%0d busy", t, c), 32'(busy), 32'(e_busy));
    endtask

    // Inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        start_valid  = 1'b0;
        start_period = '0;
        start_repeat = '0;
        abort        = 1'b0;
        #1;
        chk_cycle("rst", 0, 1, 0, 0, 0, 0);
        check("rst load_signal", 32'(load_signal), 32'd0);
        check("rst err", 32'(err), 32'd0);
        repeat (3) next_cyc();
        reset = 1'b1;

        // 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            next_cyc();
            #1;
            chk_cycle("idle", c, 1, 0, 0, 0, 0);
            check($sformatf("idle c%0d err", c), 32'(err), 32'd0);
            check($sformatf("idle c%0d lsig", c), 32'(load_signal), 32'd0);
        end

        // 2: P=3 R=1
        for (int c = 0; c < 12; c++) begin
            next_cyc();
            start_valid  = (c == 0);
            start_period = 4'd3;
            start_repeat = 4'd1;
            #1;
            chk_cycle("p3r1", c, (c == 0 || c == 11), (c == 1 || c == 5),
                      (c == 5 || c == 9), (c == 10), (c >= 1 && c <= 10));
            if (c == 1) check("p3r1 lsig", 32'(load_signal), 32'd3);
        end
        start_valid = 1'b0;

        // 3: P=0 R=3, tick every RUN cycle
        for (int c = 0; c < 8; c++) begin
            next_cyc();
            start_valid  = (c == 0);
            start_period = 4'd0;
            start_repeat = 4'd3;
            #1;
            chk_cycle("p0r3", c, (c == 0 || c == 7), (c >= 1 && c <= 4),
                      (c >= 2 && c <= 5), (c == 6), (c >= 1 && c <= 6));
        end
        start_valid = 1'b0;

        // 4: P=15 R=0, abort at c6, new job P=1 R=0 at c7
        for (int c = 0; c < 13; c++) begin
            next_cyc();
            start_valid  = (c == 0 || c == 7);
            start_period = (c < 7) ? 4'd15 : 4'd1;
            start_repeat = 4'd0;
            abort        = (c == 6);
            #1;
            chk_cycle("abort", c, (c == 0 || c == 7 || c == 12), (c == 1 || c == 8),
                      (c == 10), (c == 11), ((c >= 1 && c <= 6) || (c >= 8 && c <= 11)));
        end
        start_valid = 1'b0;
        abort       = 1'b0;

        // 5: start_valid held through the job; second job accepted after done
        for (int c = 0; c < 13; c++) begin
            next_cyc();
            start_valid  = (c <= 6);
            start_period = 4'd2;
            start_repeat = 4'd0;
            #1;
            chk_cycle("hold", c, (c == 0 || c == 6 || c == 12), (c == 1 || c == 7),
                      (c == 4 || c == 10), (c == 5 || c == 11),
                      ((c >= 1 && c <= 5) || (c >= 7 && c <= 11)));
        end
        start_valid = 1'b0;

        // 6: corrupt q while the shadow expects 4, then reset mid-job
        for (int c = 0; c < 15; c++) begin
            next_cyc();
            start_valid  = (c == 0);
            start_period = 4'd9;
            start_repeat = 4'd0;
            force_val    = 4'd5;
            force_en     = (c == 7);
            #1;
            chk_cycle("shadow", c, (c == 0 || c >= 13), (c == 1), (c == 11), (c == 12),
                      (c >= 1 && c <= 12));
            check($sformatf("shadow c%0d err", c), 32'(err), 32'(ShadowEn && c >= 8));
        end
        start_valid = 1'b0;
        force_en    = 1'b0;

        for (int c = 0; c < 3; c++) begin
            next_cyc();
            start_valid  = (c == 0);
            start_period = 4'd5;
            #1;
        end
        start_valid = 1'b0;
        check("midrst busy before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk_cycle("midrst", 0, 1, 0, 0, 0, 0);
        check("midrst err", 32'(err), 32'd0);
        next_cyc();
        reset = 1'b1;
        for (int c = 1; c < 4; c++) begin
            next_cyc();
            #1;
            chk_cycle("postrst", c, 1, 0, 0, 0, 0);
            check($sformatf("postrst c%0d err", c), 32'(err), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
